// File: rtl/sprite_palette_pkg.sv
// Shared types for the sprite palette bank.
//   rgb_t          : {red, green, blue}. Each field is MAX_COL_W wide; users
//                    slice it down to their own COL_W.
//   flash_state_t  : flash burst FSM states.
//   default_rgb()  : power-up/reset colour for palette pal, entry idx.
package sprite_palette_pkg;

    localparam int unsigned MAX_COL_W = 16;

    typedef struct packed {
        logic [MAX_COL_W-1:0] red;
        logic [MAX_COL_W-1:0] green;
        logic [MAX_COL_W-1:0] blue;
    } rgb_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } flash_state_t;

    // Reset colour is {idx ^ pal, idx, idx}, each field truncated to col_w bits.
    function automatic rgb_t default_rgb(input int unsigned pal,
                                         input int unsigned idx,
                                         input int unsigned col_w);
        rgb_t                 c;
        logic [MAX_COL_W-1:0] mask;
        mask    = MAX_COL_W'((64'd1 << col_w) - 64'd1);
        c.red   = MAX_COL_W'(idx ^ pal) & mask;
        c.green = MAX_COL_W'(idx) & mask;
        c.blue  = MAX_COL_W'(idx) & mask;
        return c;
    endfunction

endpackage

// File: rtl/palette_ram.sv
// Palette storage: NUM_PAL palettes of 2**IDX_W entries, each {r,g,b}.
// One synchronous write port and one synchronous read port. A read and write
// of the same entry in the same cycle returns the pre-write contents.
// Reset reloads every entry with default_rgb().
// Ports:
//   clk, rst_n        clock / async active-low reset
//   wr_en, wr_addr    write strobe and {pal, index} address
//   wr_data           {r,g,b} write data
//   rd_addr           {pal, index} read address (sampled every cycle)
//   rd_data           registered read data, valid one cycle after rd_addr
module palette_ram
    import sprite_palette_pkg::*;
#(
    parameter int IDX_W   = 4,
    parameter int NUM_PAL = 4,
    parameter int COL_W   = 4,
    parameter int AW      = $clog2(NUM_PAL) + IDX_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [3*COL_W-1:0] wr_data,
    input  logic [AW-1:0]      rd_addr,
    output logic [3*COL_W-1:0] rd_data
);

    localparam int unsigned ENTRIES = 2 ** IDX_W;
    localparam int unsigned DEPTH   = NUM_PAL * ENTRIES;

    logic [3*COL_W-1:0] mem_q [DEPTH];
    logic [3*COL_W-1:0] mem_d [DEPTH];
    logic [3*COL_W-1:0] rd_data_q;
    logic [3*COL_W-1:0] rd_data_d;

    function automatic logic [3*COL_W-1:0] reset_word(input int unsigned a);
        rgb_t c;
        c = default_rgb(a / ENTRIES, a % ENTRIES, COL_W);
        return {c.red[COL_W-1:0], c.green[COL_W-1:0], c.blue[COL_W-1:0]};
    endfunction

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
        rd_data_d = mem_q[rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned a = 0; a < DEPTH; a++) begin
                mem_q[a] <= reset_word(a);
            end
            rd_data_q <= '0;
        end else begin
            mem_q     <= mem_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/sprite_palette_bank.sv
// Sprite palette lookup with flash effect.
// Stage 1 reads the palette RAM and registers the transparency flag; stage 2
// applies the flash override and registers the outputs (result at N+2).
// Flash FSM:
//   state  | meaning
//   IDLE   | no burst, results pass through unchanged
//   ACTIVE | burst running; odd phases force non-transparent results white
// Ports:
//   clk, rst_n                     clock / async active-low reset
//   in_valid, in_pal, in_index     lookup request
//   frame_tick, flash_start        frame pulse / burst start (restart) pulse
//   wr_valid, wr_ready             palette write handshake (always ready)
//   wr_pal, wr_index, wr_rgb       write target and {r,g,b}
//   out_valid, red, green, blue    lookup result (colour holds when idle)
//   out_transp                     result index equals TRANSP_IDX
//   flashing                       burst active
module sprite_palette_bank
    import sprite_palette_pkg::*;
#(
    parameter int IDX_W        = 4,
    parameter int NUM_PAL      = 4,
    parameter int COL_W        = 4,
    parameter int TRANSP_IDX   = 0,
    parameter int FLASH_HALF   = 4,
    parameter int FLASH_PHASES = 6,
    parameter int PAL_W        = $clog2(NUM_PAL)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [PAL_W-1:0]   in_pal,
    input  logic [IDX_W-1:0]   in_index,
    input  logic               frame_tick,
    input  logic               flash_start,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [PAL_W-1:0]   wr_pal,
    input  logic [IDX_W-1:0]   wr_index,
    input  logic [3*COL_W-1:0] wr_rgb,
    output logic               out_valid,
    output logic [COL_W-1:0]   red,
    output logic [COL_W-1:0]   green,
    output logic [COL_W-1:0]   blue,
    output logic               out_transp,
    output logic               flashing
);

    localparam int FRM_W = $clog2(FLASH_HALF + 1);
    localparam int PH_W  = $clog2(FLASH_PHASES + 1);

    flash_state_t       state_q, state_d;
    logic [FRM_W-1:0]   frame_q, frame_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic               valid1_q, valid1_d;
    logic               transp1_q, transp1_d;
    logic               out_valid_q, out_valid_d;
    logic [3*COL_W-1:0] rgb_q, rgb_d;
    logic               transp_q, transp_d;
    logic [3*COL_W-1:0] rd_data;
    logic               flash_odd;

    assign wr_ready = 1'b1;

    palette_ram #(
        .IDX_W   (IDX_W),
        .NUM_PAL (NUM_PAL),
        .COL_W   (COL_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_valid),
        .wr_addr ({wr_pal, wr_index}),
        .wr_data (wr_rgb),
        .rd_addr ({in_pal, in_index}),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        phase_d = phase_q;
        case (state_q)
            IDLE: begin
                if (flash_start) begin
                    state_d = ACTIVE;
                    frame_d = '0;
                    phase_d = '0;
                end
            end
            ACTIVE: begin
                if (flash_start) begin
                    frame_d = '0;
                    phase_d = '0;
                end else if (frame_tick) begin
                    if (frame_q == FRM_W'(FLASH_HALF - 1)) begin
                        frame_d = '0;
                        if (phase_q == PH_W'(FLASH_PHASES - 1)) begin
                            state_d = IDLE;
                            phase_d = '0;
                        end else begin
                            phase_d = phase_q + PH_W'(1);
                        end
                    end else begin
                        frame_d = frame_q + FRM_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                frame_d = '0;
                phase_d = '0;
            end
        endcase
    end

    // Override uses the flash state seen while the result sits in stage 2.
    assign flash_odd = (state_q == ACTIVE) && phase_q[0];

    always_comb begin
        valid1_d    = in_valid;
        transp1_d   = (in_index == IDX_W'(TRANSP_IDX));
        out_valid_d = valid1_q;
        rgb_d       = rgb_q;
        transp_d    = transp_q;
        if (valid1_q) begin
            transp_d = transp1_q;
            rgb_d    = (flash_odd && !transp1_q) ? '1 : rd_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            frame_q     <= '0;
            phase_q     <= '0;
            valid1_q    <= 1'b0;
            transp1_q   <= 1'b0;
            out_valid_q <= 1'b0;
            rgb_q       <= '0;
            transp_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            phase_q     <= phase_d;
            valid1_q    <= valid1_d;
            transp1_q   <= transp1_d;
            out_valid_q <= out_valid_d;
            rgb_q       <= rgb_d;
            transp_q    <= transp_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign red        = rgb_q[3*COL_W-1 -: COL_W];
    assign green      = rgb_q[2*COL_W-1 -: COL_W];
    assign blue       = rgb_q[COL_W-1 -: COL_W];
    assign out_transp = transp_q;
    assign flashing   = (state_q == ACTIVE);

endmodule

// File: tb/tb_sprite_palette_bank.sv
module tb_sprite_palette_bank;

    localparam int IDX_W  = 4;
    localparam int NPAL   = 4;
    localparam int COL_W  = 4;
    localparam int TRANSP = 0;
    localparam int HALF   = 4;
    localparam int PHASES = 6;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [1:0]  in_pal;
    logic [3:0]  in_index;
    logic        frame_tick;
    logic        flash_start;
    logic        wr_valid;
    logic        wr_ready;
    logic [1:0]  wr_pal;
    logic [3:0]  wr_index;
    logic [11:0] wr_rgb;
    logic        out_valid;
    logic [3:0]  red, green, blue;
    logic        out_transp;
    logic        flashing;

    sprite_palette_bank #(
        .IDX_W        (IDX_W),
        .NUM_PAL      (NPAL),
        .COL_W        (COL_W),
        .TRANSP_IDX   (TRANSP),
        .FLASH_HALF   (HALF),
        .FLASH_PHASES (PHASES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_pal      (in_pal),
        .in_index    (in_index),
        .frame_tick  (frame_tick),
        .flash_start (flash_start),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_pal      (wr_pal),
        .wr_index    (wr_index),
        .wr_rgb      (wr_rgb),
        .out_valid   (out_valid),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .out_transp  (out_transp),
        .flashing    (flashing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: palette contents, flash burst as a tick count,
    // and a queue of lookups waiting for their due cycle.
    typedef struct {
        logic [11:0] rgb;
        bit          transp;
        int          due;
    } pend_t;

    logic [11:0] mem_m [NPAL][16];
    bit          f_active;
    int          f_ticks;
    pend_t       pq[$];
    logic [11:0] last_rgb;
    bit          last_transp;
    int          cyc;
    int          errors;
    int          checks;

    function automatic logic [11:0] dflt(input int p, input int i);
        return 12'((((i ^ p) & 15) << 8) | ((i & 15) << 4) | (i & 15));
    endfunction

    task automatic model_reset();
        for (int p = 0; p < NPAL; p++)
            for (int i = 0; i < 16; i++)
                mem_m[p][i] = dflt(p, i);
        f_active    = 0;
        f_ticks     = 0;
        pq.delete();
        last_rgb    = '0;
        last_transp = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step(input bit v, input int p, input int i,
                        input bit wv, input int wp, input int wi, input logic [11:0] wd,
                        input bit tick, input bit fs);
        bit          odd_now;
        bit          exp_v;
        pend_t       e;
        in_valid    = v;
        in_pal      = 2'(p);
        in_index    = 4'(i);
        wr_valid    = wv;
        wr_pal      = 2'(wp);
        wr_index    = 4'(wi);
        wr_rgb      = wd;
        frame_tick  = tick;
        flash_start = fs;
        odd_now = f_active && (((f_ticks / HALF) % 2) == 1);
        if (v) begin
            e.rgb    = mem_m[p][i];
            e.transp = (i == TRANSP);
            e.due    = cyc + 2;
            pq.push_back(e);
        end
        if (wv) mem_m[wp][wi] = wd;
        if (fs) begin
            f_active = 1;
            f_ticks  = 0;
        end else if (f_active && tick) begin
            f_ticks++;
            if (f_ticks == HALF * PHASES) begin
                f_active = 0;
                f_ticks  = 0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        exp_v = (pq.size() > 0) && (pq[0].due == cyc);
        if (exp_v) begin
            e           = pq.pop_front();
            last_rgb    = (odd_now && !e.transp) ? 12'hFFF : e.rgb;
            last_transp = e.transp;
        end
        chk("out_valid", 32'(out_valid), 32'(exp_v));
        chk("rgb", 32'({red, green, blue}), 32'(last_rgb));
        chk("out_transp", 32'(out_transp), 32'(last_transp));
        chk("flashing", 32'(flashing), 32'(f_active));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 12'h0, 0, 0);
    endtask

    task automatic do_reset();
        #2;
        rst_n       = 1'b0;
        in_valid    = 0;
        wr_valid    = 0;
        frame_tick  = 0;
        flash_start = 0;
        #1;
        model_reset();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_rgb", 32'({red, green, blue}), 32'd0);
        chk("rst_transp", 32'(out_transp), 32'd0);
        chk("rst_flashing", 32'(flashing), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        chk("post_rst_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        cyc         = 0;
        rst_n       = 1'b1;
        in_valid    = 0;
        in_pal      = 0;
        in_index    = 0;
        frame_tick  = 0;
        flash_start = 0;
        wr_valid    = 0;
        wr_pal      = 0;
        wr_index    = 0;
        wr_rgb      = 0;
        #1;
        do_reset();
        chk("wr_ready", 32'(wr_ready), 32'd1);

        // Default colour of pal 1 idx 3
        step(1, 1, 3, 0, 0, 0, 12'h0, 0, 0);
        idle(1);
        chk("dflt_p1_i3", 32'({out_valid, red, green, blue}), 32'h1233);
        idle(1);

        // Same-cycle write and lookup returns old data, next lookup new data
        step(1, 0, 5, 1, 0, 5, 12'hA5C, 0, 0);
        step(1, 0, 5, 0, 0, 0, 12'h0, 0, 0);
        chk("rd_before_wr", 32'({red, green, blue}), 32'h555);
        idle(1);
        chk("rd_after_wr", 32'({red, green, blue}), 32'hA5C);

        // Transparent index
        step(1, 2, TRANSP, 0, 0, 0, 12'h0, 0, 0);
        idle(2);

        // Flash burst: 24 frame ticks, continuous lookups incl. transparent ones
        step(1, 1, 7, 0, 0, 0, 12'h0, 0, 1);
        for (int t = 1; t <= HALF * PHASES; t++) begin
            step(1, $urandom_range(0, 3), TRANSP, 0, 0, 0, 12'h0, 0, 0);
            step(1, $urandom_range(0, 3), $urandom_range(1, 15), 0, 0, 0, 12'h0, 0, 0);
            step(1, $urandom_range(0, 3), $urandom_range(0, 15), 0, 0, 0, 12'h0, 1, 0);
            if (t == HALF + 1) chk("flash_odd_white", 32'({red, green, blue}), 32'hFFF);
        end
        idle(3);

        // Randomized traffic with writes, ticks and occasional restarts
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 15),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 3), $urandom_range(0, 15),
                 12'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0);
        end
        idle(3);

        // Reset mid-burst with requests in flight
        step(0, 0, 0, 0, 0, 0, 12'h0, 0, 1);
        for (int t = 0; t < HALF + 1; t++) step(1, 3, 9, 1, 3, 9, 12'h123, 1, 0);
        step(1, 2, 4, 0, 0, 0, 12'h0, 0, 0);
        step(1, 1, 6, 0, 0, 0, 12'h0, 0, 0);
        do_reset();
        idle(3);

        // 16 back-to-back lookups across all palettes, defaults restored
        for (int k = 0; k < 16; k++) step(1, k / 4, (k * 5 + 1) % 16, 0, 0, 0, 12'h0, 0, 0);
        idle(3);
        step(1, 3, 9, 0, 0, 0, 12'h0, 0, 0);
        idle(1);
        chk("dflt_after_rst", 32'({red, green, blue}), 32'(dflt(3, 9)));
        idle(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
